trigger_frame_packer: RTL and testbench

TRIGGER_FRAME_PACKER -- requirements
Module: trigger_frame_packer

---
 rtl/trigger_frame_packer_if.sv | 32 +++
 rtl/trigger_frame_packer.sv | 146 ++++++++++++++
 tb/tb_trigger_frame_packer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/trigger_frame_packer_if.sv
// Trigger frame packer bus interface.
// Groups the per-BX capture inputs and the GTX-facing / status outputs.
//   master : drives bx_strobe, link_data, overflow, bc0, ena_test_pat;
//            observes tx_data, tx_isk, frame_start, aligned, misalign_err, frame_cnt
//   slave  : the packer side of the same signals
interface trigger_frame_packer_if;
  localparam int unsigned DATA_W = 56;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic              bx_strobe;
  logic [DATA_W-1:0] link_data;
  logic              overflow;
  logic              bc0;
  logic              ena_test_pat;
  logic [WORD_W-1:0] tx_data;
  logic [1:0]        tx_isk;
  logic              frame_start;
  logic              aligned;
  logic              misalign_err;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output bx_strobe, link_data, overflow, bc0, ena_test_pat,
    input  tx_data, tx_isk, frame_start, aligned, misalign_err, frame_cnt
  );

  modport slave (
    input  bx_strobe, link_data, overflow, bc0, ena_test_pat,
    output tx_data, tx_isk, frame_start, aligned, misalign_err, frame_cnt
  );
endinterface

// File: rtl/trigger_frame_packer.sv
// Trigger frame packer: serialises one 56-bit BX payload into four 16-bit
// GTX words (word0 carries a K-character comma), emits idle commas between
// frames, and tracks strobe phase alignment.
// Ports:
//   clk_160  : 160 MHz clock, 4 cycles per BX
//   reset_i  : synchronous active-high reset
//   bus      : trigger_frame_packer_if.slave (capture inputs, tx word, status)
module trigger_frame_packer #(
  parameter int unsigned ALIGN_FRAMES = 4,      // 1..15
  parameter logic [7:0]  IDLE_COMMA   = 8'hBC
) (
  input  logic                   clk_160,
  input  logic                   reset_i,
  trigger_frame_packer_if.slave  bus
);

  localparam int unsigned DATA_W = 56;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GOOD_W = 4;
  localparam logic [7:0]  K23_7  = 8'hF7;
  localparam logic [7:0]  K28_7  = 8'hFC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WORD_W-1:0] IDLE_WORD = {8'h00, IDLE_COMMA};

  logic [0:0]        state_q,       state_d;
  logic [1:0]        phase_q,       phase_d;
  logic [DATA_W-1:0] payload_q,     payload_d;
  logic [7:0]        comma_q,       comma_d;
  logic [CNT_W-1:0]  frame_cnt_q,   frame_cnt_d;
  logic [GOOD_W-1:0] good_q,        good_d;
  logic              aligned_q,     aligned_d;
  logic              misalign_q,    misalign_d;
  logic [WORD_W-1:0] tx_data_q,     tx_data_d;
  logic [1:0]        tx_isk_q,      tx_isk_d;
  logic              frame_start_q, frame_start_d;

  logic [CNT_W-1:0]  frame_cnt_inc_c;
  logic [DATA_W-1:0] cap_payload_c;
  logic [7:0]        cap_comma_c;
  logic [GOOD_W-1:0] good_inc_c;

  // Capture-side values: the test pattern follows the post-increment count
  always_comb begin
    frame_cnt_inc_c = frame_cnt_q + CNT_W'(1);
    cap_payload_c   = bus.ena_test_pat
                    ? {frame_cnt_inc_c, frame_cnt_inc_c, frame_cnt_inc_c, frame_cnt_inc_c[7:0]}
                    : bus.link_data;
    if (bus.bc0)           cap_comma_c = K23_7;
    else if (bus.overflow) cap_comma_c = K28_7;
    else                   cap_comma_c = IDLE_COMMA;
    good_inc_c = (good_q == GOOD_W'(ALIGN_FRAMES)) ? good_q : good_q + GOOD_W'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    payload_d     = payload_q;
    comma_d       = comma_q;
    frame_cnt_d   = frame_cnt_q;
    good_d        = good_q;
    misalign_d    = misalign_q;
    tx_data_d     = IDLE_WORD;
    tx_isk_d      = 2'b01;
    frame_start_d = 1'b0;

    if (bus.bx_strobe) begin
      // Any strobe starts a frame; word0 goes out straight from the inputs
      state_d       = ST_RUN;
      phase_d       = 2'd0;
      payload_d     = cap_payload_c;
      comma_d       = cap_comma_c;
      frame_cnt_d   = frame_cnt_inc_c;
      tx_data_d     = {cap_payload_c[7:0], cap_comma_c};
      tx_isk_d      = 2'b01;
      frame_start_d = 1'b1;
      if (state_q == ST_RUN) begin
        if (phase_q == 2'd3) begin
          good_d = good_inc_c;
        end else begin
          good_d     = '0;
          misalign_d = 1'b1;
        end
      end else begin
        // First frame after idle never counts toward alignment
        good_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      if (phase_q == 2'd3) begin
        state_d = ST_IDLE;
        phase_d = 2'd0;
        good_d  = '0;
      end else begin
        phase_d  = phase_q + 2'd1;
        tx_isk_d = 2'b00;
        case (phase_q)
          2'd0:    tx_data_d = payload_q[23:8];
          2'd1:    tx_data_d = payload_q[39:24];
          default: tx_data_d = payload_q[55:40];
        endcase
      end
    end

    aligned_d = (good_d == GOOD_W'(ALIGN_FRAMES));
  end

  always_ff @(posedge clk_160) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      phase_q       <= 2'd0;
      payload_q     <= '0;
      comma_q       <= IDLE_COMMA;
      frame_cnt_q   <= '0;
      good_q        <= '0;
      aligned_q     <= 1'b0;
      misalign_q    <= 1'b0;
      tx_data_q     <= IDLE_WORD;
      tx_isk_q      <= 2'b01;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      payload_q     <= payload_d;
      comma_q       <= comma_d;
      frame_cnt_q   <= frame_cnt_d;
      good_q        <= good_d;
      aligned_q     <= aligned_d;
      misalign_q    <= misalign_d;
      tx_data_q     <= tx_data_d;
      tx_isk_q      <= tx_isk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_isk       = tx_isk_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.aligned      = aligned_q;
  assign bus.misalign_err = misalign_q;
  assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_trigger_frame_packer.sv
// Testbench for trigger_frame_packer: directed steps with a scoreboard of
// expected tx words (pushed on strobe, popped each cycle) and immediate
// assertions on every comparison.
module tb_trigger_frame_packer;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  isk;
    logic        fs;
  } word_t;

  localparam word_t IDLE_W = '{data: 16'h00BC, isk: 2'b01, fs: 1'b0};

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [15:0] exp_cnt = 16'h0000;
  word_t exp_q[$];

  trigger_frame_packer_if bus ();

  trigger_frame_packer #(.ALIGN_FRAMES(4), .IDLE_COMMA(8'hBC)) dut (
    .clk_160 (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, model the frame if strobing, then compare outputs
  task automatic step(input logic stb, input logic [55:0] d, input logic b0, input logic ovf);
    logic [15:0] nxt;
    logic [55:0] pd;
    logic [7:0]  cm;
    word_t       w;
    word_t       got;
    bus.bx_strobe = stb;
    bus.link_data = d;
    bus.bc0       = b0;
    bus.overflow  = ovf;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 16'h0000;
    end else if (stb) begin
      nxt     = exp_cnt + 16'd1;
      exp_cnt = nxt;
      pd = bus.ena_test_pat ? {nxt, nxt, nxt, nxt[7:0]} : d;
      cm = b0 ? 8'hF7 : (ovf ? 8'hFC : 8'hBC);
      exp_q.delete();
      exp_q.push_back('{data: {pd[7:0], cm}, isk: 2'b01, fs: 1'b1});
      exp_q.push_back('{data: pd[23:8],  isk: 2'b00, fs: 1'b0});
      exp_q.push_back('{data: pd[39:24], isk: 2'b00, fs: 1'b0});
      exp_q.push_back('{data: pd[55:40], isk: 2'b00, fs: 1'b0});
    end
    @(posedge clk);
    #1;
    bus.bx_strobe = 1'b0;
    bus.link_data = 56'({$urandom(), $urandom()});
    bus.bc0       = 1'($urandom());
    bus.overflow  = 1'($urandom());
    if (exp_q.size() > 0) w = exp_q.pop_front();
    else                  w = IDLE_W;
    got = '{data: bus.tx_data, isk: bus.tx_isk, fs: bus.frame_start};
    chk("tx_word", 32'(got), 32'(w));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
  endtask

  task automatic idle();
    step(1'b0, 56'h0, 1'b0, 1'b0);
  endtask

  // Correctly phased frame: strobe then three word cycles
  task automatic send_frame(input logic b0, input logic ovf, input logic exp_al, input logic exp_mis);
    step(1'b1, 56'({$urandom(), $urandom()}), b0, ovf);
    chk("aligned", 32'(bus.aligned), 32'(exp_al));
    chk("misalign_err", 32'(bus.misalign_err), 32'(exp_mis));
    repeat (3) idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.bx_strobe    = 1'b0;
    bus.link_data    = '0;
    bus.bc0          = 1'b0;
    bus.overflow     = 1'b0;
    bus.ena_test_pat = 1'b0;

    // Reset state
    idle();
    idle();
    chk("rst_aligned", 32'(bus.aligned), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00BC);

    // Strobe coincident with reset is dropped
    step(1'b1, 56'hDEADBEEFCAFE01, 1'b1, 1'b1);
    chk("rst_strobe_cnt", 32'(bus.frame_cnt), 32'd0);
    rst = 1'b0;

    // Single frame with the reference payload
    repeat (8) idle();
    step(1'b1, 56'h00112233445566, 1'b0, 1'b0);
    chk("ref_word0", 32'(bus.tx_data), 32'h66BC);
    repeat (3) idle();
    chk("ref_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("ref_aligned", 32'(bus.aligned), 32'd0);
    idle();

    // Back-to-back frames until aligned; frame 3 bc0+overflow, frame 4 overflow only
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Strobe one cycle early: frame restarts, sticky error, alignment lost
    step(1'b1, 56'({$urandom(), $urandom()}), 1'b0, 1'b0);
    chk("pre_slip_aligned", 32'(bus.aligned), 32'd1);
    idle();
    idle();
    step(1'b1, 56'({$urandom(), $urandom()}), 1'b0, 1'b0);
    chk("slip_aligned", 32'(bus.aligned), 32'd0);
    chk("slip_misalign", 32'(bus.misalign_err), 32'd1);
    repeat (3) idle();
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 1'b1, 1'b1);

    // Strobes stop at phase 3: idle word, alignment cleared, error kept
    idle();
    chk("stop_aligned", 32'(bus.aligned), 32'd0);
    chk("stop_misalign", 32'(bus.misalign_err), 32'd1);

    // Reset during word1 aborts the frame
    step(1'b1, 56'h0123456789ABCD, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    idle();
    chk("midrst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("midrst_tx_data", 32'(bus.tx_data), 32'h00BC);
    rst = 1'b0;
    idle();

    // Test pattern with frame_cnt preset to 16'hFFFF, then wrap
    bus.ena_test_pat = 1'b1;
    for (int i = 0; i < 65535; i++) step(1'b1, 56'({$urandom(), $urandom()}), 1'b0, 1'b0);
    repeat (3) idle();
    chk("preset_cnt", 32'(bus.frame_cnt), 32'hFFFF);
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
    step(1'b1, 56'({$urandom(), $urandom()}), 1'b1, 1'b0);
    chk("tp_word0", 32'(bus.tx_data), 32'h01F7);
    idle();
    chk("tp_word1", 32'(bus.tx_data), 32'h0001);
    idle();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
